// File: rtl/game_tick_ctrl_pkg.sv
// game_pkg: shared definitions for the game tick controller slice.
//   game_state_e  - run-control state encoding (IDLE=0 .. OVER=4)
//   TICK_DIV_50M  - base clock cycles per 0.1 s tick at 50 MHz
//   ELAPSED_W     - width of the elapsed-tenths counter
//   rr_pick()     - two-requester round-robin grant selection
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam int TICK_DIV_50M = 5000000;
  localparam int ELAPSED_W    = 10;

  // Single requester wins outright; with both asserted, fav_hi selects
  // which one is favoured this time.
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       fav_hi);
    logic [1:0] g;
    g = '0;
    unique case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = fav_hi ? 2'b10 : 2'b01;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/game_tick_ctrl_if.sv
// game_tick_ctrl_if: write-request / grant handshake between the two
// requesters (master side) and the tick controller (slave side).
//   req   [1:0] level requests, held until granted
//   grant [1:0] one-hot, one-cycle grant
interface game_tick_ctrl_if;
  logic [1:0] req;
  logic [1:0] grant;

  modport master (output req, input grant);
  modport slave  (input req, output grant);
endinterface

// File: rtl/game_tick_ctrl_prescaler.sv
// game_tick_prescaler: speed-scaled tick prescaler.
//   clk, rst_n - clock, async active-low reset
//   enable     - count this cycle
//   clear      - force counter to 0 and load the speed latch from shift
//   shift[1:0] - period = TICK_DIV >> shift, sampled at each period start
//   raw_tick   - combinational: counter is at the last cycle of its period
module game_tick_prescaler #(
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] shift,
  output logic       raw_tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       speed_latch;
  logic [CNT_W-1:0] last;

  always_comb begin
    last     = CNT_W'((TICK_DIV >> speed_latch) - 1);
    raw_tick = enable && (cnt == last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      speed_latch <= '0;
    end else if (clear) begin
      cnt         <= '0;
      speed_latch <= shift;
    end else if (enable) begin
      if (raw_tick) begin
        // New speed takes effect only from the next period.
        cnt         <= '0;
        speed_latch <= shift;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: run control and scheduling for the 0.1 s game timebase.
//   CLOCK50M   - system clock
//   KEY0       - async active-low reset
//   start/pause/stop - one-cycle commands (priority stop > pause > start)
//   speed[1:0] - tick period = TICK_DIV >> speed
//   bus        - game_tick_ctrl_if.slave: req in, grant out (one grant per
//                RUN tick, round-robin between the two requesters)
//   tick       - registered one-cycle tick pulse
//   elapsed    - tenths elapsed in RUN (wraps)
//   state      - IDLE=0 READY=1 RUN=2 PAUSE=3 OVER=4
//   time_up    - one-cycle pulse when the time limit is reached
// Optional feature: define GAME_TICK_CTRL_TIME_LIMIT_EN to end the game when
// elapsed reaches TIME_LIMIT; otherwise time_up is 0 and elapsed wraps.
module game_tick_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_50M,
  parameter int COUNTDOWN_TICKS = 30,
  parameter int TIME_LIMIT      = 600
) (
  input  logic                 CLOCK50M,
  input  logic                 KEY0,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic [1:0]           speed,
  game_tick_ctrl_if.slave      bus,
  output logic                 tick,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic [2:0]           state,
  output logic                 time_up
);

  localparam int CD_W = (COUNTDOWN_TICKS > 2) ? $clog2(COUNTDOWN_TICKS) : 1;

  game_state_e          state_q;
  logic [CD_W-1:0]      countdown;
  logic [1:0]           grant_q;
  logic                 rr_fav_hi;
  logic                 raw_tick;
  logic                 pre_en;
  logic                 pre_clr;
  logic [1:0]           pick;
  logic [ELAPSED_W-1:0] elapsed_nxt;

  // A pause in RUN holds the prescaler in that same cycle, so the phase at
  // the moment of the pause is exactly the phase resumed from.
  always_comb begin
    pre_en      = (state_q == ST_READY) || ((state_q == ST_RUN) && !pause);
    pre_clr     = (state_q == ST_IDLE) || (state_q == ST_OVER);
    pick        = rr_pick(bus.req, rr_fav_hi);
    elapsed_nxt = elapsed + 1'b1;
  end

  game_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (CLOCK50M),
    .rst_n    (KEY0),
    .enable   (pre_en),
    .clear    (pre_clr),
    .shift    (speed),
    .raw_tick (raw_tick)
  );

  always_ff @(posedge CLOCK50M or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= ST_IDLE;
      countdown <= '0;
      elapsed   <= '0;
      tick      <= 1'b0;
      grant_q   <= '0;
      rr_fav_hi <= 1'b0;
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
      time_up   <= 1'b0;
`endif
    end else begin
      tick    <= 1'b0;
      grant_q <= '0;
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
      time_up <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q   <= ST_READY;
            countdown <= CD_W'(COUNTDOWN_TICKS - 1);
            elapsed   <= '0;
          end
        end
        ST_READY: begin
          if (stop) begin
            state_q <= ST_OVER;
          end else if (raw_tick) begin
            tick <= 1'b1;
            if (countdown == '0) begin
              state_q <= ST_RUN;
            end else begin
              countdown <= countdown - 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_OVER;
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
          end else if (time_up) begin
            state_q <= ST_OVER;
`endif
          end else if (pause) begin
            state_q <= ST_PAUSE;
          end else if (raw_tick) begin
            tick    <= 1'b1;
            elapsed <= elapsed_nxt;
            grant_q <= pick;
            // Favour the other requester after any grant.
            if (pick != '0) begin
              rr_fav_hi <= pick[0];
            end
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
            if (elapsed_nxt == ELAPSED_W'(TIME_LIMIT)) begin
              time_up <= 1'b1;
            end
`endif
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state_q <= ST_OVER;
          end else if (pause) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifndef GAME_TICK_CTRL_TIME_LIMIT_EN
  assign time_up = 1'b0;
`endif

  assign state     = state_q;
  assign bus.grant = grant_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb_game_tick_ctrl: directed plus randomized bench for game_tick_ctrl with
// TICK_DIV=8, COUNTDOWN_TICKS=2, TIME_LIMIT=5. A cycle-level reference
// model tracks the game rules (remaining cycles to the next tick, ticks
// left in the countdown, last granted requester) and every cycle's outputs
// are compared against it.
module tb_game_tick_ctrl;

  localparam int TD = 8;
  localparam int CD = 2;
  localparam int TL = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       tick;
  logic [9:0] elapsed;
  logic [2:0] state;
  logic       time_up;

  game_tick_ctrl_if bus ();

  game_tick_ctrl #(
    .TICK_DIV        (TD),
    .COUNTDOWN_TICKS (CD),
    .TIME_LIMIT      (TL)
  ) dut (
    .CLOCK50M (clk),
    .KEY0     (rst_n),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .speed    (speed),
    .bus      (bus),
    .tick     (tick),
    .elapsed  (elapsed),
    .state    (state),
    .time_up  (time_up)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_st;
  int         m_rem;
  int         m_cd;
  int         m_el;
  int         m_last;
  bit         e_tick;
  bit         e_tu;
  logic [1:0] e_grant;

  int         n;
  int         el_hold;
  bit         saw_flag;
  bit         any_tu;
  int         el_at_tu;
  logic [9:0] prev_el;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_cd = 0; m_el = 0; m_last = -1;
    e_tick = 1'b0; e_tu = 1'b0; e_grant = 2'b00;
  endtask

  function automatic int period(input logic [1:0] s);
    return TD >> s;
  endfunction

  // One running cycle: returns 1 when the period completes.
  function automatic bit advance();
    if (m_rem == 1) begin
      m_rem = period(speed);
      return 1'b1;
    end
    m_rem = m_rem - 1;
    return 1'b0;
  endfunction

  task automatic arbitrate();
    int g;
    case (bus.req)
      2'b01:   g = 0;
      2'b10:   g = 1;
      2'b11:   g = (m_last == 0) ? 1 : 0;
      default: g = -1;
    endcase
    if (g >= 0) begin
      e_grant = 2'(1 << g);
      m_last  = g;
    end
  endtask

  task automatic model_step();
    bit prev_tu;
    prev_tu = e_tu;
    e_tick  = 1'b0;
    e_tu    = 1'b0;
    e_grant = 2'b00;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_st)
      0, 4: if (start) begin
        m_st = 1; m_rem = period(speed); m_cd = CD; m_el = 0;
      end
      1: if (stop) m_st = 4;
         else if (advance()) begin
           e_tick = 1'b1;
           m_cd   = m_cd - 1;
           if (m_cd == 0) m_st = 2;
         end
      2: if (stop || prev_tu) m_st = 4;
         else if (pause) m_st = 3;
         else if (advance()) begin
           e_tick = 1'b1;
           m_el   = (m_el + 1) % 1024;
           arbitrate();
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
           if (m_el == TL) e_tu = 1'b1;
`endif
         end
      3: if (stop) m_st = 4;
         else if (pause) m_st = 2;
      default: m_st = 0;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("state",   32'(state),     32'(m_st));
    check("elapsed", 32'(elapsed),   32'(m_el));
    check("tick",    32'(tick),      32'(e_tick));
    check("grant",   32'(bus.grant), 32'(e_grant));
    check("time_up", 32'(time_up),   32'(e_tu));
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!tick && cnt < 200);
  endtask

  task automatic new_game(input logic [1:0] spd);
    stop = 1'b1;
    cyc();
    speed = spd;
    start = 1'b1;
    cyc();
    for (int i = 0; i < 200 && state != 3'd2; i++) cyc();
    check("run_reached", 32'(state), 32'd2);
  endtask

  initial begin
    bus.req = 2'b00;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Countdown and first RUN tick
    speed = 2'd0;
    start = 1'b1;
    cyc();
    check("ready_state", 32'(state), 32'd1);
    wait_tick(n); check("ready_tick1_period", 32'(n), 32'd8);
    wait_tick(n); check("ready_tick2_period", 32'(n), 32'd8);
    check("run_after_tick2", 32'(state), 32'd2);
    wait_tick(n); check("run_tick_period", 32'(n), 32'd8);
    check("elapsed_first", 32'(elapsed), 32'd1);

    // Speed change mid-period applies from the next period
    repeat (3) cyc();
    speed = 2'd2;
    wait_tick(n); check("speed_cur_period", 32'(n), 32'd5);
    wait_tick(n); check("speed_new_period1", 32'(n), 32'd2);
    wait_tick(n); check("speed_new_period2", 32'(n), 32'd2);

    // Round-robin with both requesting
    new_game(2'd2);
    bus.req = 2'b11;
    wait_tick(n); check("rr_grant1", 32'(bus.grant), 32'd1);
    wait_tick(n); check("rr_grant2", 32'(bus.grant), 32'd2);
    wait_tick(n); check("rr_grant3", 32'(bus.grant), 32'd1);
    wait_tick(n); check("rr_grant4", 32'(bus.grant), 32'd2);

    // Single requester
    new_game(2'd2);
    bus.req = 2'b10;
    wait_tick(n); check("single_grant1", 32'(bus.grant), 32'd2);
    wait_tick(n); check("single_grant2", 32'(bus.grant), 32'd2);
    bus.req = 2'b00;

    // Pause at prescaler phase 5, resume keeps phase
    new_game(2'd0);
    repeat (5) cyc();
    el_hold = int'(elapsed);
    pause = 1'b1;
    cyc();
    check("pause_state", 32'(state), 32'd3);
    repeat (20) cyc();
    check("pause_elapsed_frozen", 32'(elapsed), 32'(el_hold));
    pause = 1'b1;
    cyc();
    check("resume_state", 32'(state), 32'd2);
    wait_tick(n); check("resume_tick_delay", 32'(n), 32'd3);
    check("resume_elapsed", 32'(elapsed), 32'(el_hold + 1));

    // Stop on the tick cycle
    el_hold = int'(elapsed);
    repeat (7) cyc();
    stop = 1'b1;
    cyc();
    check("stop_tick_suppressed", 32'(tick), 32'd0);
    check("stop_state", 32'(state), 32'd4);
    check("stop_elapsed", 32'(elapsed), 32'(el_hold));

    // Fastest speed: wrap or time limit
    speed = 2'd3;
    start = 1'b1;
    cyc();
`ifdef GAME_TICK_CTRL_TIME_LIMIT_EN
    saw_flag = 1'b0;
    el_at_tu = -1;
    for (int i = 0; i < 100 && state != 3'd4; i++) begin
      bus.req = 2'($urandom_range(0, 3));
      cyc();
      if (time_up) begin
        saw_flag = 1'b1;
        el_at_tu = int'(elapsed);
        check("tu_with_tick", 32'(tick), 32'd1);
      end
    end
    check("tu_seen", 32'(saw_flag), 32'd1);
    check("tu_elapsed", 32'(el_at_tu), 32'(TL));
    check("tu_over", 32'(state), 32'd4);
`else
    saw_flag = 1'b0;
    any_tu   = 1'b0;
    for (int i = 0; i < 1300 && !saw_flag; i++) begin
      bus.req = 2'($urandom_range(0, 3));
      prev_el = elapsed;
      cyc();
      if (prev_el == 10'd1023 && elapsed == 10'd0) saw_flag = 1'b1;
      if (time_up) any_tu = 1'b1;
    end
    check("elapsed_wrapped", 32'(saw_flag), 32'd1);
    check("time_up_never", 32'(any_tu), 32'd0);
`endif

    // Async reset mid-RUN with requests held
    new_game(2'd3);
    bus.req = 2'b11;
    repeat (3) cyc();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state",   32'(state),     32'd0);
    check("arst_elapsed", 32'(elapsed),   32'd0);
    check("arst_tick",    32'(tick),      32'd0);
    check("arst_grant",   32'(bus.grant), 32'd0);
    check("arst_time_up", 32'(time_up),   32'd0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    bus.req = 2'b00;
    speed = 2'd0;
    start = 1'b1;
    cyc();
    check("post_rst_ready", 32'(state), 32'd1);
    wait_tick(n); check("post_rst_tick1", 32'(n), 32'd8);
    wait_tick(n); check("post_rst_tick2", 32'(n), 32'd8);
    check("post_rst_run", 32'(state), 32'd2);

    // Randomized commands, speeds and requests
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 19) == 0);
      pause   = ($urandom_range(0, 24) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      bus.req = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
